// File: rtl/bf_uart_io_if.sv
// bfcpu io port: one request/ack handshake carrying a byte in each direction.
interface bf_uart_io_if;
  logic       io_req;
  logic       io_dir;
  logic [7:0] io_wdata;
  logic       io_ack;
  logic [7:0] io_rdata;

  modport master (output io_req, io_dir, io_wdata, input  io_ack, io_rdata);
  modport slave  (input  io_req, io_dir, io_wdata, output io_ack, io_rdata);
endinterface

// File: rtl/bf_uart_io.sv
// UART console on the bfcpu io port: io writes send one 8N1 frame, io reads
// block until the RX FIFO holds a byte and then return the oldest one.
module bf_uart_io #(
  parameter int unsigned CLK_HZ        = 50000000,
  parameter int unsigned BAUD          = 115200,
  parameter int unsigned RX_FIFO_DEPTH = 16,
  parameter logic        DIR_WRITE     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  bf_uart_io_if.slave io,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        rx_overrun
);
  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int CW = $clog2(DIV);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, ACK} io_st_t;
  io_st_t st, st_nxt;

  logic tx_start, pop;

  // ---------------- TX ----------------
  logic          tx_busy;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_left;
  logic [8:0]    tx_sh;
  logic          tx_idle;

  // Idle already on the edge that completes the stop bit, so a queued
  // write starts its frame with no gap.
  assign tx_idle = !tx_busy || (tx_cnt == '0 && tx_left == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_left <= 4'd0;
      tx_sh   <= '1;
      uart_tx <= 1'b1;
    end else if (tx_start) begin
      tx_busy <= 1'b1;
      tx_cnt  <= CNT_BIT;
      tx_left <= 4'd9;
      tx_sh   <= {1'b1, io.io_wdata};
      uart_tx <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cnt != '0) tx_cnt <= tx_cnt - CW'(1);
      else if (tx_left == 4'd0) tx_busy <= 1'b0;
      else begin
        uart_tx <= tx_sh[0];
        tx_sh   <= {1'b1, tx_sh[8:1]};
        tx_left <= tx_left - 4'd1;
        tx_cnt  <= CNT_BIT;
      end
    end
  end

  // ---------------- RX ----------------
  logic          rx_s1, rx_s2, rx_prev, rx_busy, rx_push;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;   // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]    rx_sh;

  assign rx_push = rx_busy && rx_cnt == '0 && rx_bit == 4'd9 && rx_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_busy <= 1'b0;
      rx_cnt  <= '0;
      rx_bit  <= 4'd0;
      rx_sh   <= '0;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (!rx_busy) begin
        if (rx_prev && !rx_s2) begin
          rx_busy <= 1'b1;
          rx_cnt  <= CNT_HALF;
          rx_bit  <= 4'd0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - CW'(1);
      end else begin
        rx_cnt <= CNT_BIT;
        // a start bit that is high again at mid-bit was a glitch
        if (rx_bit == 4'd0 && rx_s2) rx_busy <= 1'b0;
        else if (rx_bit == 4'd9) rx_busy <= 1'b0;
        else begin
          if (rx_bit != 4'd0) rx_sh <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 4'd1;
        end
      end
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]  mem [RX_FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        empty, full, push_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push_ok = rx_push && (!full || pop);

  always_ff @(posedge clk)
    if (push_ok) mem[wptr[AW-1:0]] <= rx_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      rx_overrun  <= 1'b0;
      io.io_rdata <= 8'h00;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop) begin
        io.io_rdata <= mem[rptr[AW-1:0]];
        rptr        <= rptr + 1'b1;
      end
      if (rx_push && full && !pop) rx_overrun <= 1'b1;
    end
  end

  // ---------------- IO FSM ----------------
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else     st <= st_nxt;

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:
        if (io.io_req) begin
          if (io.io_dir == DIR_WRITE) st_nxt = tx_idle ? ACK : WR_WAIT;
          else                        st_nxt = empty ? RD_WAIT : ACK;
        end
      WR_WAIT: if (tx_idle) st_nxt = ACK;
      RD_WAIT: if (!empty)  st_nxt = ACK;
      ACK:     if (!io.io_req) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_start = 1'b0;
    pop      = 1'b0;
    case (st)
      IDLE:
        if (io.io_req) begin
          if (io.io_dir == DIR_WRITE) tx_start = tx_idle;
          else                        pop      = !empty;
        end
      WR_WAIT: tx_start = tx_idle;
      RD_WAIT: pop      = !empty;
      default: ;
    endcase
  end

  assign io.io_ack = (st == ACK);
endmodule

// File: tb/tb_bf_uart_io.sv
// Directed + randomized bench for bf_uart_io at DIV=10, 4-entry RX FIFO.
module tb_bf_uart_io;
  localparam int DIV   = 10;
  localparam int DEPTH = 4;
  localparam int FR    = 10 * DIV;

  logic clk, rst, uart_rx, uart_tx, rx_overrun;
  bf_uart_io_if bus ();

  bf_uart_io #(.CLK_HZ(1000000), .BAUD(100000), .RX_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .io(bus), .uart_rx(uart_rx),
    .uart_tx(uart_tx), .rx_overrun(rx_overrun));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0, nerr = 0;
  logic q_tx[$];
  logic q_ack[$];
  logic [7:0] mq[$];   // reference RX FIFO contents
  logic m_ovr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    q_tx.push_back(uart_tx);
    q_ack.push_back(bus.io_ack);
  endtask

  // line level k clocks into a frame carrying b
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    return f[k / DIV];
  endfunction

  task automatic check_tx(input string tag, input int s, input logic [7:0] bs[$]);
    int n, bad;
    logic e;
    n = bs.size() * FR + 2 * DIV;
    bad = 0;
    while (q_tx.size() < s + n) tick();
    for (int k = 0; k < n; k++) begin
      e = (k < bs.size() * FR) ? exp_tx(bs[k / FR], k % FR) : 1'b1;
      if (q_tx[s + k] !== e) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (DIV) tick();
    end
    uart_rx = 1'b1;
    repeat (DIV) tick();
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    drive_frame(b, stop);
    if (stop) begin
      if (mq.size() < DEPTH) mq.push_back(b);
      else m_ovr = 1'b1;
    end
  endtask

  task automatic rd_wait(input string tag, input logic [7:0] exp, input int bound);
    int n;
    n = 0;
    bus.io_req = 1'b1;
    bus.io_dir = 1'b0;
    while (bus.io_ack !== 1'b1 && n < bound) begin tick(); n++; end
    chk({tag, " ack"}, bus.io_ack, 1);
    chk({tag, " data"}, bus.io_rdata, exp);
    bus.io_req = 1'b0;
    tick();
    chk({tag, " drop"}, bus.io_ack, 0);
  endtask

  task automatic rd_model(input string tag);
    logic [7:0] e;
    e = (mq.size() > 0) ? mq.pop_front() : 8'hxx;
    rd_wait(tag, e, 20);
  endtask

  // start a write and return the index of the frame-start sample
  task automatic wr_issue(input string tag, input logic [7:0] b, output int s);
    int n;
    n = 0;
    bus.io_req = 1'b1;
    bus.io_dir = 1'b1;
    bus.io_wdata = b;
    tick();
    while (bus.io_ack !== 1'b1 && n < 2 * FR) begin tick(); n++; end
    chk({tag, " ack"}, bus.io_ack, 1);
    s = q_tx.size() - 1;
  endtask

  initial begin
    int s, ones, n;
    logic [7:0] b, b2;
    logic [7:0] bq[$];

    rst = 1'b1; uart_rx = 1'b1;
    bus.io_req = 1'b0; bus.io_dir = 1'b0; bus.io_wdata = 8'h00;
    #12;
    chk("rst ack", bus.io_ack, 0);
    chk("rst rdata", bus.io_rdata, 8'h00);
    chk("rst tx", uart_tx, 1);
    chk("rst ovr", rx_overrun, 0);
    #10 rst = 1'b0;
    repeat (3) tick();

    // 1: single write of 0x41, request held 5 clocks past ack
    chk("t1 pre-ack", bus.io_ack, 0);
    bus.io_req = 1'b1; bus.io_dir = 1'b1; bus.io_wdata = 8'h41;
    tick();
    chk("t1 ack 1 edge", bus.io_ack, 1);
    chk("t1 start bit", uart_tx, 0);
    s = q_tx.size() - 1;
    ones = 0;
    repeat (5) begin tick(); ones += int'(bus.io_ack); end
    chk("t1 ack held", ones, 5);
    bus.io_req = 1'b0;
    tick();
    chk("t1 ack drop", bus.io_ack, 0);
    bq.delete(); bq.push_back(8'h41);
    check_tx("t1 frame 0x41", s, bq);

    // 2: back-to-back writes, second waits for TX and frames are gapless
    wr_issue("t2 w1", 8'h55, s);
    bus.io_req = 1'b0;
    tick();
    bus.io_req = 1'b1; bus.io_wdata = 8'hAA;
    n = 0;
    while (bus.io_ack !== 1'b1 && n < 2 * FR) begin tick(); n++; end
    chk("t2 ack at +100", q_ack.size() - 1 - s, FR);
    chk("t2 no early ack", q_ack[s + FR - 1], 0);
    bus.io_req = 1'b0;
    bq.delete(); bq.push_back(8'h55); bq.push_back(8'hAA);
    check_tx("t2 gapless", s, bq);

    // 3: blocking read, glitch first, then 0x3C
    bus.io_req = 1'b1; bus.io_dir = 1'b0;
    uart_rx = 1'b0;
    repeat (3) tick();
    uart_rx = 1'b1;
    repeat (3 * DIV) tick();
    chk("t3 glitch ignored", bus.io_ack, 0);
    s = q_ack.size();
    drive_frame(8'h3C, 1'b1);
    ones = 0;
    for (int k = 0; k < 95; k++) ones += int'(q_ack[s + k]);
    chk("t3 no ack before stop", ones, 0);
    chk("t3 ack by frame end", q_ack[s + FR - 1], 1);
    rd_wait("t3 rd", 8'h3C, 5);

    // 5: framing error discarded, valid byte follows
    rx_send(8'h7E, 1'b0);
    rx_send(8'h11, 1'b1);
    rd_model("t5 rd");
    chk("t5 ovr", rx_overrun, 0);

    // 4: overrun on the fifth byte, four reads, fifth blocks
    for (int i = 1; i <= 5; i++) begin
      rx_send(8'(i), 1'b1);
      if (i == 4) chk("t4 ovr after 4", rx_overrun, m_ovr);
    end
    chk("t4 ovr after 5", rx_overrun, m_ovr);
    chk("t4 ovr set", rx_overrun, 1);
    for (int i = 0; i < 4; i++) rd_model("t4 rd");
    bus.io_req = 1'b1; bus.io_dir = 1'b0;
    repeat (3 * DIV) tick();
    chk("t4 5th blocks", bus.io_ack, 0);
    b = 8'($urandom);
    drive_frame(b, 1'b1);
    rd_wait("t4 late rd", b, 5);

    // 6: reset mid TX and mid RX
    rx_send(8'hC3, 1'b1);
    wr_issue("t6 w", 8'h5A, s);
    uart_rx = 1'b0;
    repeat (30) tick();
    rst = 1'b1;
    #1;
    chk("t6 tx idle", uart_tx, 1);
    chk("t6 ack low", bus.io_ack, 0);
    chk("t6 ovr clr", rx_overrun, 0);
    bus.io_req = 1'b0; uart_rx = 1'b1;
    mq.delete(); m_ovr = 1'b0;
    #3 rst = 1'b0;
    tick();
    b2 = 8'($urandom);
    rx_send(b2, 1'b1);
    rd_model("t6 fifo empty");
    wr_issue("t6 w00", 8'h00, s);
    bus.io_req = 1'b0;
    bq.delete(); bq.push_back(8'h00);
    check_tx("t6 frame 0x00", s, bq);

    // randomized traffic against the queue model
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++)
        rx_send(8'($urandom), $urandom_range(0, 4) != 0);
      chk("rnd ovr", rx_overrun, m_ovr);
      while (mq.size() > 0) rd_model("rnd rd");
      b = 8'($urandom);
      wr_issue("rnd w", b, s);
      bus.io_req = 1'b0;
      bq.delete(); bq.push_back(b);
      check_tx("rnd frame", s, bq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
